mc_unit_scheduler: RTL and testbench

- Shares one fixed-latency multi-cycle functional unit among NREQ requesters, such as reservation-station entries.
- Grants one requester per cycle using round-robin priority and drives the unit's input.
- Tracks each in-flight operation's tag so completion is signalled exactly LATENCY cycles after the grant.
- Supports a pipelined unit or a non-pipelined (blocking) unit.

---
 rtl/mc_unit_scheduler.sv | 163 ++++++++++++++++
 tb/tb_mc_unit_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_unit_scheduler.sv
// mc_unit_scheduler: shares one fixed-latency multi-cycle functional unit among
// NREQ requesters. It uses round-robin arbitration, registers the unit input and
// tracks tags so that each operation completes LATENCY enabled cycles after its grant.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable              global advance; 0 stalls the whole block
//   flush               synchronous kill of every in-flight operation
//   req/req_tag/req_instr  request vector plus packed per-requester tag and instruction
//   grant               one-hot grant for the current cycle (combinational)
//   issue_valid/instr/tag  registered unit input
//   done_valid/done_tag completion strobe and the tag of the completing operation
//   unit_ready          unit can accept an operation this cycle
//   inflight            count of operations in flight
// Optional: defining MC_UNIT_SCHEDULER_PERF_EN adds the saturating counters
//   perf_grants, perf_conflicts and perf_busy_stalls.
module mc_unit_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned SIZE      = 32,
  parameter int unsigned TAGW      = 5,
  parameter int unsigned PIPELINED = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*TAGW-1:0]           req_tag,
  input  logic [NREQ*SIZE-1:0]           req_instr,
  output logic [NREQ-1:0]                grant,
  output logic                           issue_valid,
  output logic [SIZE-1:0]                issue_instr,
  output logic [TAGW-1:0]                issue_tag,
  output logic                           done_valid,
  output logic [TAGW-1:0]                done_tag,
  output logic                           unit_ready,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
`ifdef MC_UNIT_SCHEDULER_PERF_EN
  ,
  output logic [31:0]                    perf_grants,
  output logic [31:0]                    perf_conflicts,
  output logic [31:0]                    perf_busy_stalls
`endif
);

  localparam int unsigned PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW  = $clog2(LATENCY + 1);
  localparam int unsigned BUSYW = $clog2(LATENCY);

  logic [PTRW-1:0]    rrPtr;
  logic [PTRW-1:0]    grantIdx;
  logic               grantAny;
  logic [TAGW-1:0]    selTag;
  logic [SIZE-1:0]    selInstr;
  logic [LATENCY-1:0] stageValid;
  logic [LATENCY-1:0] nextValid;
  logic [TAGW-1:0]    stageTag [LATENCY];
  logic [BUSYW-1:0]   busyCnt;
  logic [CNTW-1:0]    inflightReg;

  // Acceptance: a blocking unit also waits for the busy countdown to drain.
  always_comb begin
    unit_ready = enable & ~flush;
    if (PIPELINED == 0 && busyCnt != '0) unit_ready = 1'b0;
  end

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    int unsigned cand;
    grantAny = 1'b0;
    grantIdx = '0;
    cand     = 0;
    if (unit_ready) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cand = (32'(rrPtr) + i) % NREQ;
        if (!grantAny && req[PTRW'(cand)]) begin
          grantAny = 1'b1;
          grantIdx = PTRW'(cand);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grantAny) grant = NREQ'(1) << grantIdx;
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    selTag   = '0;
    selInstr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        selTag   = req_tag[i*TAGW +: TAGW];
        selInstr = req_instr[i*SIZE +: SIZE];
      end
    end
  end

  // Next state of the completion pipeline; flush wins over a stall.
  always_comb begin
    nextValid = stageValid;
    if (flush) nextValid = '0;
    else if (enable) nextValid = {stageValid[LATENCY-2:0], grantAny};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr       <= '0;
      stageValid  <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) stageTag[k] <= '0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_tag   <= '0;
      busyCnt     <= '0;
      inflightReg <= '0;
    end else begin
      stageValid  <= nextValid;
      inflightReg <= CNTW'($countones(nextValid));
      if (grantAny) rrPtr <= (grantIdx == PTRW'(NREQ - 1)) ? '0 : grantIdx + PTRW'(1);
      if (flush) begin
        issue_valid <= 1'b0;
        busyCnt     <= '0;
      end else if (enable) begin
        issue_valid <= grantAny;
        if (grantAny) begin
          issue_instr <= selInstr;
          issue_tag   <= selTag;
        end
        stageTag[0] <= selTag;
        for (int unsigned k = 1; k < LATENCY; k++) stageTag[k] <= stageTag[k-1];
        // Countdown of LATENCY-1 frees the unit in the cycle its operation completes.
        if (PIPELINED == 0 && grantAny) busyCnt <= BUSYW'(LATENCY - 1);
        else if (busyCnt != '0) busyCnt <= busyCnt - BUSYW'(1);
      end
    end
  end

  // A flushed cycle reports an empty unit straight away.
  assign done_valid = stageValid[LATENCY-1] & enable & ~flush;
  assign done_tag   = stageTag[LATENCY-1];
  assign inflight   = flush ? '0 : inflightReg;

`ifdef MC_UNIT_SCHEDULER_PERF_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants      <= '0;
      perf_conflicts   <= '0;
      perf_busy_stalls <= '0;
    end else begin
      if (grantAny && perf_grants != '1) perf_grants <= perf_grants + 32'd1;
      if (enable && ((req & (req - NREQ'(1))) != '0) && perf_conflicts != '1)
        perf_conflicts <= perf_conflicts + 32'd1;
      if (enable && req != '0 && !unit_ready && perf_busy_stalls != '1)
        perf_busy_stalls <= perf_busy_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_unit_scheduler.sv
// Bench for mc_unit_scheduler: a pipelined and a blocking instance. Completions
// of the pipelined instance are matched against a queue of expected {tag, cycle}.
module tb_mc_unit_scheduler;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 4;
  localparam int unsigned SIZE = 32;
  localparam int unsigned TAGW = 5;
  localparam int unsigned CNTW = $clog2(LAT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic fl  = 1'b0;

  logic [NREQ-1:0]      reqP = '0;
  logic [TAGW-1:0]      tP [NREQ] = '{default: '0};
  logic [SIZE-1:0]      iP [NREQ] = '{default: '0};
  logic [NREQ*TAGW-1:0] tagP;
  logic [NREQ*SIZE-1:0] instrP;
  logic [NREQ-1:0]      grantP;
  logic                 ivP, dvP, urP;
  logic [SIZE-1:0]      iinstrP;
  logic [TAGW-1:0]      itagP, dtagP;
  logic [CNTW-1:0]      inflP;

  logic [NREQ-1:0]      reqB = '0;
  logic [TAGW-1:0]      tB [NREQ] = '{default: '0};
  logic [SIZE-1:0]      iB [NREQ] = '{default: '0};
  logic [NREQ*TAGW-1:0] tagB;
  logic [NREQ*SIZE-1:0] instrB;
  logic [NREQ-1:0]      grantB;
  logic                 ivB, dvB, urB;
  logic [SIZE-1:0]      iinstrB;
  logic [TAGW-1:0]      itagB, dtagB;
  logic [CNTW-1:0]      inflB;

`ifdef MC_UNIT_SCHEDULER_PERF_EN
  logic [31:0] pgP, pcP, psP, pgB, pcB, psB;
`endif

  assign tagP   = {tP[3], tP[2], tP[1], tP[0]};
  assign instrP = {iP[3], iP[2], iP[1], iP[0]};
  assign tagB   = {tB[3], tB[2], tB[1], tB[0]};
  assign instrB = {iB[3], iB[2], iB[1], iB[0]};

  mc_unit_scheduler #(.NREQ(NREQ), .LATENCY(LAT), .SIZE(SIZE), .TAGW(TAGW), .PIPELINED(1)) dutP (
    .clock(clk), .reset(rst), .enable(en), .flush(fl),
    .req(reqP), .req_tag(tagP), .req_instr(instrP), .grant(grantP),
    .issue_valid(ivP), .issue_instr(iinstrP), .issue_tag(itagP),
    .done_valid(dvP), .done_tag(dtagP), .unit_ready(urP), .inflight(inflP)
`ifdef MC_UNIT_SCHEDULER_PERF_EN
    , .perf_grants(pgP), .perf_conflicts(pcP), .perf_busy_stalls(psP)
`endif
  );

  mc_unit_scheduler #(.NREQ(NREQ), .LATENCY(LAT), .SIZE(SIZE), .TAGW(TAGW), .PIPELINED(0)) dutB (
    .clock(clk), .reset(rst), .enable(en), .flush(fl),
    .req(reqB), .req_tag(tagB), .req_instr(instrB), .grant(grantB),
    .issue_valid(ivB), .issue_instr(iinstrB), .issue_tag(itagB),
    .done_valid(dvB), .done_tag(dtagB), .unit_ready(urB), .inflight(inflB)
`ifdef MC_UNIT_SCHEDULER_PERF_EN
    , .perf_grants(pgB), .perf_conflicts(pcB), .perf_busy_stalls(psB)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { int tag; int due; } expT;
  expT sb[$];
  expT e;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    int         tag;
    int         infl;
    logic       iv;
    int         itag;
  } rowT;
  rowT rr [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Completion scoreboard for the pipelined instance.
  always @(negedge clk) begin
    if (dvP === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got tag %0d at cycle %0d, want no completion", dtagP, cyc);
      end else begin
        e = sb.pop_front();
        check("done_tag", 32'(dtagP), 32'(e.tag));
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL done_missing: got none at cycle %0d, want tag %0d at cycle %0d", cyc, e.tag, e.due);
    end
  end

  initial begin
    rr[0]  = '{4'hF, 4'h1, 0, 0, 1'b0, 0};
    rr[1]  = '{4'hF, 4'h2, 1, 1, 1'b1, 0};
    rr[2]  = '{4'hF, 4'h4, 2, 2, 1'b1, 1};
    rr[3]  = '{4'hF, 4'h8, 3, 3, 1'b1, 2};
    rr[4]  = '{4'hF, 4'h1, 0, 4, 1'b1, 3};
    rr[5]  = '{4'hF, 4'h2, 1, 4, 1'b1, 0};
    rr[6]  = '{4'hF, 4'h4, 2, 4, 1'b1, 1};
    rr[7]  = '{4'hF, 4'h8, 3, 4, 1'b1, 2};
    rr[8]  = '{4'h0, 4'h0, 0, 4, 1'b1, 3};
    rr[9]  = '{4'h0, 4'h0, 0, 3, 1'b0, 0};
    rr[10] = '{4'h0, 4'h0, 0, 2, 1'b0, 0};
    rr[11] = '{4'h0, 4'h0, 0, 1, 1'b0, 0};
    rr[12] = '{4'h0, 4'h0, 0, 0, 1'b0, 0};

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    mid();
    check("rst grantP", 32'(grantP), 32'd0);
    check("rst doneP", 32'(dvP), 32'd0);
    check("rst readyP", 32'(urP), 32'd1);
    check("rst ivP", 32'(ivP), 32'd0);
    check("rst itagP", 32'(itagP), 32'd0);
    check("rst iinstrP", iinstrP, 32'd0);
    check("rst inflP", 32'(inflP), 32'd0);
    check("rst readyB", 32'(urB), 32'd1);
    check("rst doneB", 32'(dvB), 32'd0);

    // Basic issue and completion
    tick();
    tP[0] = 5'h03; iP[0] = 32'hDEAD0001; reqP = 4'b0001;
    sb.push_back('{3, cyc + 4});
    mid();
    check("basic grant", 32'(grantP), 32'd1);
    tick(); reqP = '0; mid();
    check("basic iv", 32'(ivP), 32'd1);
    check("basic itag", 32'(itagP), 32'd3);
    check("basic iinstr", iinstrP, 32'hDEAD0001);
    check("basic infl1", 32'(inflP), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick(); mid();
      check($sformatf("basic infl%0d", k), 32'(inflP), 32'd1);
      if (k == 2) check("basic iv drop", 32'(ivP), 32'd0);
    end
    tick(); mid();
    check("basic infl5", 32'(inflP), 32'd0);

    // Round-robin table from a fresh pointer
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tP[i] = 5'(i);
      iP[i] = 32'hA0000000 + 32'(i);
    end
    for (int r = 0; r < 13; r++) begin
      tick();
      reqP = rr[r].req;
      if (rr[r].grant != 4'h0) sb.push_back('{rr[r].tag, cyc + 4});
      mid();
      check($sformatf("rr%0d grant", r), 32'(grantP), 32'(rr[r].grant));
      check($sformatf("rr%0d infl", r), 32'(inflP), 32'(rr[r].infl));
      check($sformatf("rr%0d iv", r), 32'(ivP), 32'(rr[r].iv));
      if (rr[r].iv) check($sformatf("rr%0d itag", r), 32'(itagP), 32'(rr[r].itag));
    end
`ifdef MC_UNIT_SCHEDULER_PERF_EN
    check("perf grants", pgP, 32'd8);
    check("perf conflicts", pcP, 32'd8);
    check("perf busy", psP, 32'd0);
`endif

    // Stall: pointer is 0, requester 1 wins
    tP[1] = 5'd7; tP[2] = 5'd9;
    tick(); reqP = 4'b0010;
    sb.push_back('{7, cyc + 7});
    mid();
    check("stall grant", 32'(grantP), 32'h2);
    tick(); reqP = '0; mid();
    check("stall itag", 32'(itagP), 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick(); en = 1'b0; reqP = 4'b0100; mid();
      check($sformatf("stall%0d grant", k), 32'(grantP), 32'd0);
      check($sformatf("stall%0d ready", k), 32'(urP), 32'd0);
      check($sformatf("stall%0d infl", k), 32'(inflP), 32'd1);
    end
    tick(); en = 1'b1; reqP = 4'b0101;
    sb.push_back('{9, cyc + 4});
    mid();
    check("stall ptr held", 32'(grantP), 32'h4);
    tick(); reqP = '0; mid();
    check("stall infl2", 32'(inflP), 32'd2);
    check("stall itag2", 32'(itagP), 32'd9);
    repeat (4) begin tick(); mid(); end

    // Flush with three ops in flight; pointer is 3
    for (int i = 0; i < 4; i++) tP[i] = 5'(10 + i);
    tick(); reqP = 4'hF; mid();
    check("fl grant0", 32'(grantP), 32'h8);
    tick(); mid();
    check("fl grant1", 32'(grantP), 32'h1);
    tick(); mid();
    check("fl grant2", 32'(grantP), 32'h2);
    check("fl infl pre", 32'(inflP), 32'd2);
    tick(); fl = 1'b1; en = 1'b0; mid();
    check("fl grant", 32'(grantP), 32'd0);
    check("fl infl", 32'(inflP), 32'd0);
    check("fl done", 32'(dvP), 32'd0);
    check("fl ready", 32'(urP), 32'd0);
    tick(); fl = 1'b0; en = 1'b1;
    sb.push_back('{12, cyc + 4});
    mid();
    check("fl ptr held", 32'(grantP), 32'h4);
    check("fl infl post", 32'(inflP), 32'd0);
    check("fl iv cleared", 32'(ivP), 32'd0);
    tick(); reqP = '0; mid();
    check("fl infl next", 32'(inflP), 32'd1);
    check("fl itag next", 32'(itagP), 32'd12);
    repeat (6) begin tick(); mid(); end

    // Reset mid-operation; pointer back to 0 afterwards
    tP[0] = 5'd17;
    tick(); reqP = 4'b1000; mid();
    check("rm grant pre", 32'(grantP), 32'h8);
    tick(); reqP = '0; rst = 1'b1; mid();
    tick(); rst = 1'b0; reqP = 4'b1001;
    sb.push_back('{17, cyc + 4});
    mid();
    check("rm grant", 32'(grantP), 32'h1);
    check("rm infl", 32'(inflP), 32'd0);
    check("rm iv", 32'(ivP), 32'd0);
    tick(); reqP = '0; mid();
    repeat (6) begin tick(); mid(); end

    // Blocking unit: grants every LATENCY cycles, completion meets next grant
    tB[0] = 5'd21; tB[1] = 5'd22;
    for (int k = 0; k <= 12; k++) begin
      tick(); reqB = (k < 12) ? 4'b0011 : 4'b0000; mid();
      check($sformatf("blk%0d grant", k), 32'(grantB),
            (k < 12 && k % 4 == 0) ? (((k / 4) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      check($sformatf("blk%0d ready", k), 32'(urB), (k % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("blk%0d done", k), 32'(dvB), (k >= 4 && k % 4 == 0) ? 32'd1 : 32'd0);
      if (k >= 4 && k % 4 == 0)
        check($sformatf("blk%0d dtag", k), 32'(dtagB), (((k / 4) - 1) % 2 == 0) ? 32'd21 : 32'd22);
      check($sformatf("blk%0d infl", k), 32'(inflB), (k == 0) ? 32'd0 : 32'd1);
    end
`ifdef MC_UNIT_SCHEDULER_PERF_EN
    check("perfB grants", pgB, 32'd3);
    check("perfB conflicts", pcB, 32'd12);
    check("perfB busy", psB, 32'd9);
`endif
    tick(); mid();

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
